sine_sequencer: RTL and testbench

- Drives the 7-bit address of the sine decoder (the 128-entry quarter-wave DAC cell table) and the polarity switch of the current DAC.
- Walks a full sine period as four 128-step quarters at a programmable step rate.
- Runs for a programmed number of periods or continuously.
- Stops only at a zero crossing.

---
 rtl/sine_seq_pkg.sv | 28 ++
 rtl/sine_step_timer.sv | 38 +++
 rtl/sine_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sine_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_seq_pkg.sv
// ----------------------------------------------------------------------------
// sine_seq_pkg
// Shared definitions for the sine sequencer and its helpers:
//   - state_t    : sequencer states (IDLE, RUN, STOPPING)
//   - quarter_t  : quarter-wave index; bit 1 is the DAC polarity
//   - Q_*        : quarter encodings in the order a period walks them
//   - ADDR_MAX   : last address of the default 128-entry decoder table
// ----------------------------------------------------------------------------
package sine_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    typedef logic [1:0] quarter_t;

    // Rising/falling refers to the DAC magnitude; _P/_N is the half-wave sign.
    localparam quarter_t Q_RISE_P = 2'd0;
    localparam quarter_t Q_FALL_P = 2'd1;
    localparam quarter_t Q_RISE_N = 2'd2;
    localparam quarter_t Q_FALL_N = 2'd3;

    localparam int ADDR_W_DEFAULT = 7;
    localparam int ADDR_MAX       = 2**ADDR_W_DEFAULT - 1;

endpackage

// File: rtl/sine_step_timer.sv
// ----------------------------------------------------------------------------
// sine_step_timer
// Programmable step-rate divider. Produces one step strobe every div_q+1
// enabled clocks; div_q = 0 steps on every enabled clock.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   clear  in   forces the tick counter to 0 (held while the owner is idle)
//   en     in   advance enable; low holds the tick count
//   div_q  in   clocks per step minus 1
//   step   out  step strobe, valid in the cycle the step is taken
// ----------------------------------------------------------------------------
module sine_step_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div_q,
    output logic             step
);

    logic [DIV_W-1:0] tick;

    assign step = en && (tick == div_q);

    // NOTE: sequential state is written with <= only, so every register in
    // this and the parent block samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= '0;
        end else if (en) begin
            tick <= step ? '0 : tick + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sine_sequencer.sv
// ----------------------------------------------------------------------------
// sine_sequencer
// Walks the quarter-wave decoder through full sine periods (four quarters of
// 2**ADDR_W steps each) at a programmable step rate, for a programmed number
// of periods or continuously. A stop request is only honoured at the end of
// a period so the DAC is always switched off at a zero crossing.
//
// Optional build macro: SINE_SEQ_PHASE_OFFSET_EN adds input phase0, giving
// the starting quarter and position of the first (partial) period.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   en        in   step enable; low freezes a running sequence
//   start     in   one-cycle start request (ignored while busy)
//   stop      in   one-cycle graceful stop request (ignored while idle)
//   div       in   clocks per step minus 1, latched at start
//   cycles    in   periods to generate, 0 = continuous, latched at start
//   phase0    in   {quarter, position} start phase (macro builds only)
//   addr      out  registered decoder address
//   polarity  out  0 = positive half-wave, 1 = negative half-wave
//   dac_en    out  DAC output enable
//   busy      out  high in RUN or STOPPING
//   done      out  one-cycle pulse when the sequence ends
// ----------------------------------------------------------------------------
module sine_sequencer
    import sine_seq_pkg::*;
#(
    parameter int ADDR_W = $clog2(ADDR_MAX + 1),
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    input  logic [CNT_W-1:0]  cycles,
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    input  logic [ADDR_W+1:0] phase0,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              polarity,
    output logic              dac_en,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    state_t            state;
    quarter_t          quarter;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  cycles_q;
    logic [CNT_W-1:0]  periods;
    logic [CNT_W-1:0]  periods_nx;
    logic              running;
    logic              step;
    logic              finish;
    quarter_t          start_q;
    logic [ADDR_W-1:0] start_addr;

    assign running  = (state != IDLE);
    assign polarity = quarter[1];

    sine_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!running),
        .en    (en && running),
        .div_q (div_q),
        .step  (step)
    );

    // Period counter saturates so continuous runs never wrap into a match.
    assign periods_nx = (periods == '1) ? periods : periods + CNT_W'(1);

    // A stop arriving on the final step of a period ends that same period.
    assign finish = (state == STOPPING) || stop ||
                    ((cycles_q != '0) && (periods_nx == cycles_q));

`ifdef SINE_SEQ_PHASE_OFFSET_EN
    // Falling quarters address the table backwards from the top.
    assign start_q    = phase0[ADDR_W+1:ADDR_W];
    assign start_addr = start_q[0] ? ADDR_TOP - phase0[ADDR_W-1:0]
                                   : phase0[ADDR_W-1:0];
`else
    assign start_q    = Q_RISE_P;
    assign start_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here is control state, so all of it is
            // reset; there is no storage array that could skip reset.
            state    <= IDLE;
            quarter  <= Q_RISE_P;
            addr     <= '0;
            div_q    <= '0;
            cycles_q <= '0;
            periods  <= '0;
            dac_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_q    <= div;
                        cycles_q <= cycles;
                        periods  <= '0;
                        quarter  <= start_q;
                        addr     <= start_addr;
                        dac_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN, STOPPING: begin
                    if (state == RUN && stop) begin
                        state <= STOPPING;
                    end
                    if (step) begin
                        case (quarter)
                            Q_RISE_P, Q_RISE_N: begin
                                // Top of a rising quarter: hold addr, turn.
                                if (addr == ADDR_TOP) quarter <= quarter + 2'd1;
                                else                  addr    <= addr + ADDR_W'(1);
                            end
                            Q_FALL_P: begin
                                if (addr == '0) quarter <= Q_RISE_N;
                                else            addr    <= addr - ADDR_W'(1);
                            end
                            default: begin // Q_FALL_N
                                if (addr == '0) begin
                                    periods <= periods_nx;
                                    quarter <= Q_RISE_P;
                                    // NOTE: this later <= overrides the
                                    // STOPPING transition made above when
                                    // both fire on the same edge.
                                    if (finish) begin
                                        state  <= IDLE;
                                        dac_en <= 1'b0;
                                        busy   <= 1'b0;
                                        done   <= 1'b1;
                                    end
                                end else begin
                                    addr <= addr - ADDR_W'(1);
                                end
                            end
                        endcase
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_sequencer.sv
module tb_sine_sequencer;

    localparam int ADDR_W = 7;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 8;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              en     = 1'b1;
    logic              start  = 1'b0;
    logic              stop   = 1'b0;
    logic [DIV_W-1:0]  div    = '0;
    logic [CNT_W-1:0]  cycles = '0;
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    logic [ADDR_W+1:0] phase0 = '0;
`endif
    logic [ADDR_W-1:0] addr;
    logic              polarity;
    logic              dac_en;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sine_sequencer #(
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .div      (div),
        .cycles   (cycles),
`ifdef SINE_SEQ_PHASE_OFFSET_EN
        .phase0   (phase0),
`endif
        .addr     (addr),
        .polarity (polarity),
        .dac_en   (dac_en),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected address for step k of a phase-0 period at one step per sample.
    function automatic logic [ADDR_W-1:0] exp_addr(input int k);
        int j;
        j = k % 512;
        if (j < 128)      return ADDR_W'(j);
        else if (j < 256) return ADDR_W'(255 - j);
        else if (j < 384) return ADDR_W'(j - 256);
        else              return ADDR_W'(511 - j);
    endfunction

    function automatic logic exp_pol(input int k);
        return (k % 512) >= 256;
    endfunction

    // Called on a negedge; drives one start pulse, returns on the negedge
    // after the start edge (first RUN sample).
    task automatic start_seq(input int d, input int c, input bit with_stop);
        @(negedge clk);
        div    = DIV_W'(d);
        cycles = CNT_W'(c);
        start  = 1'b1;
        stop   = with_stop;
        @(negedge clk);
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    // Counts busy samples (up to budget); optionally checks addr/polarity
    // against the div=0 model starting at step index base.
    task automatic run_seq(input int budget, input int base, input bit chk,
                           output int blen, output int aerr,
                           output logic [ADDR_W-1:0] last_addr, output logic last_pol);
        blen = 0;
        aerr = 0;
        last_addr = '0;
        last_pol  = 1'b0;
        while (busy === 1'b1 && blen < budget) begin
            if (chk && (addr !== exp_addr(base + blen) || polarity !== exp_pol(base + blen)))
                aerr++;
            if (dac_en !== 1'b1 || done !== 1'b0) aerr++;
            last_addr = addr;
            last_pol  = polarity;
            blen++;
            @(negedge clk);
        end
    endtask

    // On the first idle sample after a run: done high with outputs at rest,
    // then done low one cycle later.
    task automatic end_checks(input string tag);
        check({tag, "_done_rise"}, done, 1);
        check({tag, "_idle_out"}, {addr, polarity, dac_en, busy}, 0);
        @(negedge clk);
        check({tag, "_done_fall"}, done, 0);
    endtask

    initial begin
        int bl, b1, b2, b3, ae, ae1, ae2, gerr, dcnt;
        logic [ADDR_W-1:0] la, frozen;
        logic lp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_polarity", polarity, 0);
        check("rst_dac_en", dac_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Basic run: div=0, one period
        start_seq(0, 1, 0);
        check("basic_first_busy", busy, 1);
        check("basic_first_addr", addr, 0);
        run_seq(2000, 0, 1, bl, ae, la, lp);
        check("basic_busy_len", bl, 512);
        check("basic_addr_seq", ae, 0);
        end_checks("basic");

        // Slow rate, two periods
        start_seq(3, 2, 0);
        run_seq(10000, 0, 0, bl, ae, la, lp);
        check("slow_busy_len", bl, 4096);
        end_checks("slow");

        // Same with a 10-cycle en gap
        start_seq(3, 2, 0);
        run_seq(1000, 0, 0, b1, ae, la, lp);
        en = 1'b0;
        frozen = addr;
        gerr = 0;
        b2 = 0;
        for (int i = 0; i < 10; i++) begin
            if (addr !== frozen || busy !== 1'b1) gerr++;
            b2++;
            @(negedge clk);
        end
        en = 1'b1;
        run_seq(10000, 0, 0, b3, ae, la, lp);
        check("gap_addr_frozen", gerr, 0);
        check("gap_busy_len", b1 + b2 + b3, 4106);
        end_checks("gap");

        // Graceful stop at step 100 of period 3 (div=1, continuous)
        start_seq(1, 0, 0);
        run_seq(2248, 0, 0, b1, ae, la, lp);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        run_seq(10000, 0, 0, b3, ae, la, lp);
        check("stop_busy_len", b1 + 1 + b3, 3072);
        check("stop_last_addr", la, 0);
        check("stop_last_pol", lp, 1);
        end_checks("stop");

        // start+stop together in IDLE
        start_seq(0, 1, 1);
        run_seq(2000, 0, 1, bl, ae, la, lp);
        check("ss_busy_len", bl, 512);
        check("ss_addr_seq", ae, 0);
        end_checks("ss");

        // start while busy (with different div/cycles) has no effect
        start_seq(0, 1, 0);
        run_seq(50, 0, 1, b1, ae1, la, lp);
        start  = 1'b1;
        div    = DIV_W'(5);
        cycles = CNT_W'(3);
        run_seq(1, 50, 1, b2, ae2, la, lp);
        start  = 1'b0;
        run_seq(2000, 51, 1, b3, ae, la, lp);
        check("rebusy_busy_len", b1 + b2 + b3, 512);
        check("rebusy_addr_seq", ae1 + ae2 + ae, 0);
        end_checks("rebusy");

        // stop in IDLE has no effect
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_state", {busy, dac_en, done}, 0);
        repeat (3) @(negedge clk);
        check("idle_stop_busy", busy, 0);
        start_seq(0, 2, 0);
        run_seq(3000, 0, 1, bl, ae, la, lp);
        check("idle_stop_len", bl, 1024);
        check("idle_stop_addr", ae, 0);
        end_checks("idle_stop");

        // Reset mid-run at step 300
        start_seq(0, 0, 0);
        run_seq(300, 0, 1, bl, ae, la, lp);
        check("rstrun_pre_addr", ae, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_out", {addr, polarity, dac_en, busy, done}, 0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dcnt++;
            @(negedge clk);
        end
        check("rstrun_no_done", dcnt, 0);

`ifdef SINE_SEQ_PHASE_OFFSET_EN
        // Phase offset: q2, position 64, one period
        phase0 = 9'h140;
        start_seq(0, 1, 0);
        check("phase_first_addr", addr, 64);
        check("phase_first_pol", polarity, 1);
        bl = 0;
        ae = 0;
        while (busy === 1'b1 && bl < 1000) begin
            if (addr !== ADDR_W'((bl < 64) ? 64 + bl : 191 - bl) || polarity !== 1'b1) ae++;
            bl++;
            @(negedge clk);
        end
        check("phase_busy_len", bl, 192);
        check("phase_addr_seq", ae, 0);
        end_checks("phase");
        phase0 = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
